wordle_scorer: RTL
==================

// Module: wordle_scorer
// PURPOSE
//  Downstream of the guess state machine. Scores one completed 5-letter ASCII guess
//  against the word of the day and produces per-letter green/yellow/grey codes for the
//  display. Duplicate letters are handled with a two-pass algorithm: exact matches first,
//  then misplaced matches against target letters not yet consumed.
// PARAMETERS
//  NLET    5   letters per word (fixed; other values unsupported)
//  LW      8   bits per letter (ASCII)
// PORTS
//  Clk        in   1   system clock, all logic on rising edge
//  reset_n    in   1   synchronous active-low reset
//  start      in   1   request scoring; sampled only in IDLE
//  guess      in   40  guess word, letter0 = guess[39:32] ... letter4 = guess[7:0]
//  target     in   40  word of the day, same packing as guess
//  busy       out  1   high in GREEN and YELLOW states
//  done       out  1   one-cycle pulse, results valid from this cycle
//  score      out  10  2b per letter, letter0 = score[9:8]; 00 grey, 01 yellow, 10 green
//  all_green  out  1   score == 10'b1010101010 (win indication)
//  invalid    out  1   a guess letter was outside 'A'..'Z'
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge): state IDLE; score, done, busy, all_green, invalid = 0;
//    internal used-flags and index cleared. Reset wins over every other input, including mid-run.
//  - States: IDLE, GREEN, YELLOW, DONE. Index i is 3 bits, range 0..4.
//  - IDLE: at an edge with start=1, latch guess/target into internal regs (inputs may change
//    afterwards), clear score, all_green, invalid and used[4:0].
//    - If all 5 guess letters are in 'A'..'Z': go to GREEN with i=0.
//    - Otherwise: set invalid=1, keep score=0, go to DONE.
//  - GREEN: one letter per edge. If g[i]==t[i]: score[i]=10 and used[i]=1.
//    i increments; after i=4, go to YELLOW with i=0.
//  - YELLOW: one letter per edge. If score[i]!=10, find the lowest j with used[j]==0 and
//    t[j]==g[i]. If found: score[i]=01 and used[j]=1; else score[i] stays 00.
//    After i=4, go to DONE.
//  - DONE: done=1 for exactly one cycle, all_green valid, then IDLE.
//    score, all_green and invalid hold until the next accepted start or reset.
//  - Latency for a valid guess, with start sampled at edge E: GREEN runs edges E+1..E+5,
//    YELLOW runs E+6..E+10, done is high in the cycle after E+10.
//    Invalid guess: done is high in the cycle after E.
//  - start while busy or in DONE is ignored (not queued). The next start is accepted on the
//    first edge in IDLE.
//  - At most one yellow per unused target letter, so repeated guess letters beyond the
//    target's count score grey. Green always takes priority over yellow for the same target letter.
//  - busy and done are never high together. No combinational path from inputs to outputs.
// TESTING
//  1 target "ROBOT", guess "ROBOT", start pulse -> done 10 cycles later, score=10'b1010101010,
//    all_green=1, invalid=0
//  2 target "BANAL", guess "CACAO" -> score=10'b0010001000, all_green=0
//  3 target "ABBOT", guess "BANAL" (duplicate A) -> score=10'b0101000000
//    (second A grey: target A already consumed)
//  4 guess "RE1EW" -> done in the cycle after the start edge, invalid=1, score=0, busy never high
//  5 start pulsed again at E+3 with a different guess -> ignored; first result delivered
//    unchanged; a new start after done is accepted
//  6 reset_n=0 at E+7 mid-run -> next cycle IDLE, all outputs 0; no done pulse appears.
//    Change guess/target at E+1 on a normal run -> result uses the values latched at E.

Source files
------------

// File: rtl/wordle_scorer_if.sv
// Request/result bundle between the guess state machine and the scorer.
interface wordle_scorer_if #(
  parameter int NLET = 5,
  parameter int LW   = 8
);
  logic                 start;
  logic [NLET*LW-1:0]   guess;
  logic [NLET*LW-1:0]   target;
  logic                 busy;
  logic                 done;
  logic [2*NLET-1:0]    score;
  logic                 all_green;
  logic                 invalid;

  modport master (output start, guess, target,
                  input  busy, done, score, all_green, invalid);
  modport slave  (input  start, guess, target,
                  output busy, done, score, all_green, invalid);
endinterface

// File: rtl/wordle_scorer.sv
// Scores a 5-letter guess against the word of the day, one letter per cycle:
// a green pass marks exact matches, then a yellow pass consumes unused target letters.
module wordle_scorer #(
  parameter int NLET = 5,
  parameter int LW   = 8
) (
  input logic              Clk,
  input logic              reset_n,
  wordle_scorer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, GREEN, YELLOW, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [NLET-1:0] used_q, used_d;
  logic [LW-1:0]   g_q [NLET], g_d [NLET];
  logic [LW-1:0]   t_q [NLET], t_d [NLET];
  logic [LW-1:0]   g_in [NLET], t_in [NLET];
  logic [1:0]      sc_q [NLET], sc_d [NLET];
  logic            inv_q, inv_d;
  logic            ag_q, ag_d;
  logic            letters_ok;
  logic            found;

  always_comb begin
    letters_ok = 1'b1;
    for (int unsigned k = 0; k < NLET; k++) begin
      g_in[k] = bus.guess[(NLET-1-k)*LW +: LW];
      t_in[k] = bus.target[(NLET-1-k)*LW +: LW];
      if (g_in[k] < 8'h41 || g_in[k] > 8'h5A) letters_ok = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    used_d  = used_q;
    g_d     = g_q;
    t_d     = t_q;
    sc_d    = sc_q;
    inv_d   = inv_q;
    ag_d    = ag_q;
    found   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          g_d    = g_in;
          t_d    = t_in;
          used_d = '0;
          idx_d  = '0;
          ag_d   = 1'b0;
          for (int unsigned k = 0; k < NLET; k++) sc_d[k] = 2'b00;
          if (letters_ok) begin
            inv_d   = 1'b0;
            state_d = GREEN;
          end else begin
            inv_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      GREEN: begin
        if (g_q[idx_q] == t_q[idx_q]) begin
          sc_d[idx_q]   = 2'b10;
          used_d[idx_q] = 1'b1;
        end
        if (idx_q == 3'(NLET-1)) begin
          idx_d   = '0;
          state_d = YELLOW;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      YELLOW: begin
        // Lowest unused matching target letter wins; greens already hold their used bit.
        if (sc_q[idx_q] != 2'b10) begin
          for (int unsigned j = 0; j < NLET; j++) begin
            if (!found && !used_q[j] && t_q[j] == g_q[idx_q]) begin
              found       = 1'b1;
              used_d[j]   = 1'b1;
              sc_d[idx_q] = 2'b01;
            end
          end
        end
        if (idx_q == 3'(NLET-1)) begin
          state_d = DONE;
          ag_d    = 1'b1;
          for (int unsigned k = 0; k < NLET; k++)
            if (sc_d[k] != 2'b10) ag_d = 1'b0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      idx_q  <= '0;
      used_q <= '0;
      inv_q  <= 1'b0;
      ag_q   <= 1'b0;
      for (int unsigned k = 0; k < NLET; k++) begin
        g_q[k]  <= '0;
        t_q[k]  <= '0;
        sc_q[k] <= 2'b00;
      end
    end else begin
      idx_q  <= idx_d;
      used_q <= used_d;
      inv_q  <= inv_d;
      ag_q   <= ag_d;
      g_q    <= g_d;
      t_q    <= t_d;
      sc_q   <= sc_d;
    end
  end

  always_comb begin
    bus.score = '0;
    for (int unsigned k = 0; k < NLET; k++)
      bus.score[(NLET-1-k)*2 +: 2] = sc_q[k];
  end

  assign bus.busy      = (state_q == GREEN) || (state_q == YELLOW);
  assign bus.done      = (state_q == DONE);
  assign bus.all_green = ag_q;
  assign bus.invalid   = inv_q;

endmodule
